// File: rtl/igbt_pkg.sv
// Shared types and constants for the IGBT gate-pulse sequencer.
package igbt_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_PULSE,
        S_DEAD,
        S_DONE
    } state_t;

    localparam int unsigned CTRL_EN       = 0;
    localparam int unsigned CTRL_START    = 1;
    localparam int unsigned CTRL_ABORT    = 2;
    localparam int unsigned CTRL_REPEAT   = 3;
    localparam int unsigned CTRL_MASK_LSB = 4;

    localparam int unsigned ST_BUSY    = 0;
    localparam int unsigned ST_DONE    = 1;
    localparam int unsigned ST_ABORTED = 2;
    localparam int unsigned ST_CLAMPED = 3;
    localparam int unsigned ST_CH_LSB  = 4;

    // Largest value ever loaded is max(MAX_LEN, DEAD_TIME) - 1, so this width never wraps.
    function automatic int unsigned cnt_width(input int unsigned max_len, input int unsigned dead_time);
        int unsigned m;
        m = (max_len > dead_time) ? max_len : dead_time;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/igbt_down_counter.sv
// Loadable down-counter with zero flag, shared by the pulse and dead-time phases.
module igbt_down_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/igbt_pulse_gen.sv
// Sequences one HPS start command into non-overlapping, width-clamped IGBT gate pulses.
module igbt_pulse_gen
    import igbt_pkg::*;
#(
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_W     = 32,
    parameter int unsigned DEAD_TIME = 50,
    parameter int unsigned MAX_LEN   = 50000
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             ctrl,
    input  logic [NUM_CH*CNT_W-1:0] pulse_len,
    output logic [NUM_CH-1:0]       gate_out,
    output logic                    done,
    output logic [7:0]              status
);

    localparam int unsigned CW = cnt_width(MAX_LEN, DEAD_TIME);

    state_t            state;
    logic              start_q;
    logic [NUM_CH-1:0] shadow_mask;
    logic [CNT_W-1:0]  shadow_len [NUM_CH];
    logic [CNT_W-1:0]  len_in     [NUM_CH];
    logic [NUM_CH-1:0] mask_in, clamp_in, qual_in, qual;
    logic [1:0]        cur, first_in, first, next;
    logic              first_in_ok, first_ok, next_ok;
    logic              done_s, abort_s, clamp_s;
    logic              start_edge, halt, go;
    logic              cnt_load, cnt_en, cnt_zero;
    logic [CW-1:0]     cnt_val;
    logic              unused_ctrl;

    assign mask_in     = ctrl[CTRL_MASK_LSB +: NUM_CH];
    assign start_edge  = ctrl[CTRL_START] & ~start_q;
    assign halt        = ctrl[CTRL_ABORT] | ~ctrl[CTRL_EN];
    assign go          = (state == S_IDLE) && start_edge && !halt;
    assign unused_ctrl = ^ctrl[31:CTRL_MASK_LSB+NUM_CH];

    // Qualification is evaluated on the live inputs for the start decision and on the shadows afterwards.
    always_comb begin
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            clamp_in[i] = pulse_len[i*CNT_W +: CNT_W] > CNT_W'(MAX_LEN);
            len_in[i]   = clamp_in[i] ? CNT_W'(MAX_LEN) : pulse_len[i*CNT_W +: CNT_W];
            qual_in[i]  = mask_in[i] && (len_in[i] != '0);
            qual[i]     = shadow_mask[i] && (shadow_len[i] != '0);
        end
    end

    always_comb begin
        first_in_ok = 1'b0;
        first_in    = '0;
        first_ok    = 1'b0;
        first       = '0;
        next_ok     = 1'b0;
        next        = '0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (qual_in[i] && !first_in_ok) begin
                first_in_ok = 1'b1;
                first_in    = 2'(i);
            end
            if (qual[i] && !first_ok) begin
                first_ok = 1'b1;
                first    = 2'(i);
            end
            if (qual[i] && (i > 32'(cur)) && !next_ok) begin
                next_ok = 1'b1;
                next    = 2'(i);
            end
        end
    end

    always_comb begin
        cnt_load = 1'b0;
        cnt_val  = '0;
        cnt_en   = (state == S_PULSE) || (state == S_DEAD);
        case (state)
            S_IDLE: if (go && first_in_ok) begin
                cnt_load = 1'b1;
                cnt_val  = CW'(len_in[first_in] - 1'b1);
            end
            S_PULSE: if (!halt && cnt_zero) begin
                cnt_load = 1'b1;
                cnt_val  = CW'(DEAD_TIME - 1);
            end
            S_DEAD: if (!halt && cnt_zero && (next_ok || ctrl[CTRL_REPEAT])) begin
                cnt_load = 1'b1;
                cnt_val  = CW'(shadow_len[next_ok ? next : first] - 1'b1);
            end
            default: ;
        endcase
    end

    igbt_down_counter #(.W(CW)) u_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            start_q     <= 1'b0;
            shadow_mask <= '0;
            shadow_len  <= '{default: '0};
            gate_out    <= '0;
            done        <= 1'b0;
            cur         <= '0;
            done_s      <= 1'b0;
            abort_s     <= 1'b0;
            clamp_s     <= 1'b0;
        end else begin
            start_q <= ctrl[CTRL_START];
            done    <= 1'b0;
            if (state == S_IDLE) begin
                if (go) begin
                    shadow_mask <= mask_in;
                    shadow_len  <= len_in;
                    abort_s     <= 1'b0;
                    clamp_s     <= |clamp_in;
                    if (first_in_ok) begin
                        state    <= S_PULSE;
                        cur      <= first_in;
                        gate_out <= NUM_CH'(1'b1) << first_in;
                        done_s   <= 1'b0;
                    end else begin
                        state  <= S_DONE;
                        done   <= 1'b1;
                        done_s <= 1'b1;
                    end
                end
            end else if (halt) begin
                // Abort outranks the end-of-phase decision taken in the same cycle.
                state    <= S_IDLE;
                gate_out <= '0;
                cur      <= '0;
                abort_s  <= 1'b1;
            end else begin
                case (state)
                    S_PULSE: if (cnt_zero) begin
                        state    <= S_DEAD;
                        gate_out <= '0;
                    end
                    S_DEAD: if (cnt_zero) begin
                        if (next_ok || ctrl[CTRL_REPEAT]) begin
                            state    <= S_PULSE;
                            cur      <= next_ok ? next : first;
                            gate_out <= NUM_CH'(1'b1) << (next_ok ? next : first);
                        end else begin
                            state  <= S_DONE;
                            done   <= 1'b1;
                            done_s <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        state <= S_IDLE;
                        cur   <= '0;
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

    assign status = {2'b00, cur, clamp_s, abort_s, done_s, (state != S_IDLE)};

endmodule

// File: tb/tb_igbt_pulse_gen.sv
// Self-checking bench: directed table, trace-model random runs, and hand-written abort/reset sequences.
module tb_igbt_pulse_gen;

    localparam int unsigned DEAD = 50;
    localparam int unsigned MAXL = 50000;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  ctrl;
    logic [127:0] pulse_len;
    logic [3:0]   gate_out;
    logic         done;
    logic [7:0]   status;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [4:0] exp_q [$];

    typedef struct {
        logic [3:0]  mask;
        int unsigned l0, l1, l2, l3;
        int unsigned exp_busy;
        logic [7:0]  exp_status;
    } vec_t;

    vec_t vecs [6];

    igbt_pulse_gen #(
        .NUM_CH    (4),
        .CNT_W     (32),
        .DEAD_TIME (DEAD),
        .MAX_LEN   (MAXL)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ctrl      (ctrl),
        .pulse_len (pulse_len),
        .gate_out  (gate_out),
        .done      (done),
        .status    (status)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got timeout required completion");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected per-cycle {done, gate} after the start edge, built from the pulse list.
    task automatic build_trace(input logic [3:0] mask, input int unsigned lens[4], input int unsigned reps);
        int unsigned w;
        bit first_p;
        first_p = 1'b1;
        exp_q.delete();
        for (int unsigned r = 0; r < reps; r++) begin
            for (int unsigned c = 0; c < 4; c++) begin
                w = (lens[c] > MAXL) ? MAXL : lens[c];
                if (mask[c] && w != 0) begin
                    if (!first_p) repeat (DEAD) exp_q.push_back(5'b0);
                    first_p = 1'b0;
                    repeat (w) exp_q.push_back({1'b0, 4'(1 << c)});
                end
            end
        end
        if (!first_p) repeat (DEAD) exp_q.push_back(5'b0);
        exp_q.push_back(5'b1_0000);
    endtask

    task automatic run_seq(input logic [3:0] mask, input int unsigned lens[4], input int unsigned reps,
                           input bit perturb, output int unsigned busy_cyc, output logic [7:0] st_end);
        int unsigned clear_at;
        logic [1:0]  ch;
        build_trace(mask, lens, reps);
        clear_at = (reps > 1) ? exp_q.size() - 60 : 0;
        ctrl = {24'b0, mask, (reps > 1), 3'b001};
        for (int c = 0; c < 4; c++) pulse_len[c*32 +: 32] = lens[c];
        tick();
        ctrl[1] = 1'b1;
        busy_cyc = 0;
        for (int unsigned k = 0; k < exp_q.size(); k++) begin
            tick();
            check("trace", {27'b0, done, status[0], gate_out}, {27'b0, exp_q[k][4], 1'b1, exp_q[k][3:0]});
            if (status[0]) busy_cyc++;
            if (exp_q[k][3:0] != 4'b0) begin
                ch = 2'd0;
                for (int c = 0; c < 4; c++) if (exp_q[k][c]) ch = 2'(c);
                check("cur_ch", {30'b0, status[5:4]}, {30'b0, ch});
            end
            if (!perturb && k == 0) ctrl[1] = 1'b0;
            if (perturb && k == 1) ctrl[1] = 1'b0;
            if (perturb && k == 3) begin
                ctrl[1]   = 1'b1;
                pulse_len = {$urandom, $urandom, $urandom, $urandom};
            end
            if (reps > 1 && k == clear_at) ctrl[3] = 1'b0;
        end
        repeat (6) begin
            tick();
            if (status[0]) busy_cyc++;
        end
        st_end = status;
    endtask

    initial begin
        int unsigned lens [4];
        int unsigned busy;
        logic [7:0]  st;
        int unsigned waited;
        bit          seen;

        vecs[0] = '{4'b0001,     10, 0, 0, 0,    61, 8'h02};
        vecs[1] = '{4'b1111,      5, 0, 7, 3,   166, 8'h02};
        vecs[2] = '{4'b0000,      9, 9, 9, 9,     1, 8'h02};
        vecs[3] = '{4'b1010,      0, 2, 9, 1,   104, 8'h02};
        vecs[4] = '{4'b0001, 100000, 0, 0, 0, 50051, 8'h0A};
        vecs[5] = '{4'b0100,      0, 0, 1, 0,    52, 8'h02};

        reset     = 1'b1;
        ctrl      = '0;
        pulse_len = '0;
        repeat (3) tick();
        check("reset_gate", {28'b0, gate_out}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_status", {24'b0, status}, 32'h0);
        reset = 1'b0;
        tick();

        for (int i = 0; i < 6; i++) begin
            lens = '{vecs[i].l0, vecs[i].l1, vecs[i].l2, vecs[i].l3};
            run_seq(vecs[i].mask, lens, 1, 1'b0, busy, st);
            check("vec_busy_cycles", busy, vecs[i].exp_busy);
            check("vec_status", {24'b0, st}, {24'b0, vecs[i].exp_status});
        end

        for (int i = 0; i < 16; i++) begin
            for (int c = 0; c < 4; c++) lens[c] = $urandom_range(0, 12);
            run_seq(4'($urandom), lens, 1, 1'($urandom), busy, st);
            check("rand_status", {24'b0, st}, 32'h02);
        end

        lens = '{4, 4, 0, 0};
        run_seq(4'b0011, lens, 3, 1'b0, busy, st);
        check("repeat_status", {24'b0, st}, 32'h02);

        // Abort in the middle of a channel-2 pulse.
        ctrl      = {24'b0, 4'b0100, 4'b0001};
        pulse_len = '0;
        pulse_len[64 +: 32] = 20;
        tick();
        ctrl[1] = 1'b1;
        waited  = 0;
        do begin
            tick();
            waited++;
        end while (!gate_out[2] && waited < 10);
        check("abort_rise_latency", waited, 1);
        ctrl[1] = 1'b0;
        repeat (3) tick();
        ctrl[2] = 1'b1;
        tick();
        check("abort_gate", {28'b0, gate_out}, 32'h0);
        check("abort_status", {24'b0, status}, 32'h04);
        seen = 1'b0;
        repeat (60) begin
            tick();
            if (done || gate_out != 4'b0) seen = 1'b1;
        end
        check("abort_no_done", {31'b0, seen}, 32'h0);
        ctrl[1] = 1'b1;
        tick();
        tick();
        check("start_with_abort_status", {24'b0, status}, 32'h04);
        check("start_with_abort_gate", {28'b0, gate_out}, 32'h0);

        // Abort sampled on the very edge the pulse would end.
        ctrl      = {24'b0, 4'b0001, 4'b0001};
        pulse_len = '0;
        pulse_len[31:0] = 6;
        tick();
        ctrl[1] = 1'b1;
        tick();
        check("edge_abort_rise", {28'b0, gate_out}, 32'h1);
        ctrl[1] = 1'b0;
        repeat (5) tick();
        check("edge_abort_last_high", {28'b0, gate_out}, 32'h1);
        ctrl[2] = 1'b1;
        tick();
        check("edge_abort_status", {24'b0, status}, 32'h04);
        check("edge_abort_gate", {28'b0, gate_out}, 32'h0);

        // Reset in the middle of a pulse.
        ctrl      = {24'b0, 4'b0001, 4'b0001};
        pulse_len = '0;
        pulse_len[31:0] = 30;
        tick();
        ctrl[1] = 1'b1;
        repeat (5) tick();
        check("pre_reset_gate", {28'b0, gate_out}, 32'h1);
        reset = 1'b1;
        tick();
        check("mid_reset_gate", {28'b0, gate_out}, 32'h0);
        check("mid_reset_status", {24'b0, status}, 32'h0);
        check("mid_reset_done", {31'b0, done}, 32'h0);
        reset = 1'b0;
        ctrl  = '0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
